dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of Data_Memory. Requester 0 is the core load/store path; requester 1 is the debug/DMA loader port.
- Grants one request per cycle, round-robin between the two requesters.
- Registers the granted request onto the memory strobes for one cycle, captures the aligned read data, and returns it to the winner two cycles after acceptance.
- Fully pipelined: back-to-back accepts at one per cycle, no response backpressure.

---
 rtl/dmem_arb_pkg.sv | 32 +++
 rtl/rr_arb2.sv | 35 +++
 rtl/dmem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the Data_Memory arbiter slice.
// Optional misalignment screening is enabled with DMEM_ARB_MISALIGN_CHECK_EN.
package dmem_arb_pkg;

  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_ADDR_W = 10;

  // Access size encoded in funct3[1:0]
  localparam logic [1:0] F3_B = 2'b00;
  localparam logic [1:0] F3_H = 2'b01;
  localparam logic [1:0] F3_W = 2'b10;

  typedef logic [0:0] req_id_t;

  typedef struct packed {
    logic                   we;
    logic [2:0]             func3;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      F3_H:    mis = addr_lo[0];
      F3_W:    mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; the pointer register lives in the parent.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last_grant,
  output logic [1:0] grant_c,
  output req_id_t    grant_id_c
);

  always_comb begin
    grant_c    = 2'b00;
    grant_id_c = req_id_t'(1'b0);
    unique case (valid)
      2'b01: begin
        grant_c    = 2'b01;
        grant_id_c = req_id_t'(1'b0);
      end
      2'b10: begin
        grant_c    = 2'b10;
        grant_id_c = req_id_t'(1'b1);
      end
      2'b11: begin
        // Contention: favour whoever did not win last time
        grant_id_c = ~last_grant;
        grant_c    = (last_grant == req_id_t'(1'b0)) ? 2'b10 : 2'b01;
      end
      default: begin
        grant_c    = 2'b00;
        grant_id_c = req_id_t'(1'b0);
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of Data_Memory: accept, access, respond.
// Build option DMEM_ARB_MISALIGN_CHECK_EN adds misaligned-access blocking and reqN_err outputs.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_BITS  = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [2:0]            req0_func3,
  input  logic [ADDR_BITS-1:0]  req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_rvalid,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [2:0]            req1_func3,
  input  logic [ADDR_BITS-1:0]  req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_rvalid,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [2:0]            mem_func3,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
  ,
  output logic                  req0_err,
  output logic                  req1_err
`endif
);

  logic [1:0]            valid_c;
  logic [1:0]            grant_c;
  req_id_t               win_id_c;
  logic                  any_grant_c;
  logic                  mis_c;
  logic                  fwd_c;
  dmem_req_t             req0_c;
  dmem_req_t             req1_c;
  dmem_req_t             win_c;
  logic [DATA_WIDTH-1:0] load_data_c;

  req_id_t               last_grant_q, last_grant_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [2:0]            mem_func3_q, mem_func3_d;
  logic [ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  s1_valid_q, s1_valid_d;
  req_id_t               s1_id_q, s1_id_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  // Nothing is offered to the arbiter while reset is held
  assign valid_c = {req1_valid, req0_valid} & {2{reset_n}};

  rr_arb2 u_rr_arb2 (
    .valid      (valid_c),
    .last_grant (last_grant_q),
    .grant_c    (grant_c),
    .grant_id_c (win_id_c)
  );

  assign any_grant_c = |grant_c;

  always_comb begin
    req0_c = '{we: req0_we, func3: req0_func3,
               addr: DMEM_ADDR_W'(req0_addr), wdata: DMEM_DATA_W'(req0_wdata)};
    req1_c = '{we: req1_we, func3: req1_func3,
               addr: DMEM_ADDR_W'(req1_addr), wdata: DMEM_DATA_W'(req1_wdata)};
    win_c  = (win_id_c == req_id_t'(1'b1)) ? req1_c : req0_c;
  end

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
  logic s1_mis_q, s1_mis_d;
  logic err0_q, err0_d;
  logic err1_q, err1_d;

  assign mis_c = is_misaligned(win_c.func3[1:0], win_c.addr[1:0]);
`else
  assign mis_c = 1'b0;
`endif

  // A granted but blocked request still flows through the pipeline, just without strobes
  assign fwd_c       = any_grant_c & ~mis_c;
  assign load_data_c = mem_read_q ? mem_rdata : '0;

  always_comb begin
    last_grant_d = any_grant_c ? win_id_c : last_grant_q;
    mem_read_d   = fwd_c & ~win_c.we;
    mem_write_d  = fwd_c & win_c.we;
    mem_func3_d  = any_grant_c ? win_c.func3 : mem_func3_q;
    mem_addr_d   = any_grant_c ? ADDR_BITS'(win_c.addr) : mem_addr_q;
    mem_wdata_d  = any_grant_c ? DATA_WIDTH'(win_c.wdata) : mem_wdata_q;
    s1_valid_d   = any_grant_c;
    s1_id_d      = win_id_c;
    rvalid_d     = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    if (s1_valid_q) begin
      rvalid_d[s1_id_q] = 1'b1;
      if (s1_id_q == req_id_t'(1'b0)) rdata0_d = load_data_c;
      else                            rdata1_d = load_data_c;
    end
  end

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
  always_comb begin
    s1_mis_d = mis_c;
    err0_d   = s1_valid_q & s1_mis_q & (s1_id_q == req_id_t'(1'b0));
    err1_d   = s1_valid_q & s1_mis_q & (s1_id_q == req_id_t'(1'b1));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_mis_q <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      s1_mis_q <= s1_mis_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  assign req0_err = err0_q & reset_n;
  assign req1_err = err1_q & reset_n;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= req_id_t'(1'b1);
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_func3_q  <= 3'b000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      s1_valid_q   <= 1'b0;
      s1_id_q      <= req_id_t'(1'b0);
      rvalid_q     <= 2'b00;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_func3_q  <= mem_func3_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      rvalid_q     <= rvalid_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Strobes and pulses are masked by reset so an in-flight store never commits during reset
  assign req0_ready  = grant_c[0];
  assign req1_ready  = grant_c[1];
  assign mem_read    = mem_read_q & reset_n;
  assign mem_write   = mem_write_q & reset_n;
  assign mem_func3   = mem_func3_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign req0_rvalid = rvalid_q[0] & reset_n;
  assign req1_rvalid = rvalid_q[1] & reset_n;
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: Data_Memory stand-in, transaction-level model, directed tests.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic        req0_we = 1'b0, req1_we = 1'b0;
  logic [2:0]  req0_func3 = 3'b0, req1_func3 = 3'b0;
  logic [9:0]  req0_addr = 10'd0, req1_addr = 10'd0;
  logic [31:0] req0_wdata = 32'd0, req1_wdata = 32'd0;
  logic        req0_rvalid, req1_rvalid;
  logic [31:0] req0_rdata, req1_rdata;
  logic        mem_read, mem_write;
  logic [2:0]  mem_func3;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
  logic        req0_err, req1_err;
`endif

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_BITS(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_func3(req0_func3), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_func3(req1_func3), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_func3(mem_func3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    , .req0_err(req0_err), .req1_err(req1_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- Data_Memory stand-in and golden byte store ----------------
  logic [7:0] env_mem  [0:1023];
  logic [7:0] gold_mem [0:1023];

  function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b100:  return {24'd0, raw[7:0]};
      3'b101:  return {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  always_comb
    mem_rdata = ext(mem_func3, {env_mem[10'(mem_addr + 10'd3)], env_mem[10'(mem_addr + 10'd2)],
                                env_mem[10'(mem_addr + 10'd1)], env_mem[mem_addr]});

  always @(posedge clk)
    if (mem_write)
      for (int i = 0; i < nbytes(mem_func3); i++)
        env_mem[10'(mem_addr + 10'(i))] <= mem_wdata[8*i +: 8];

  function automatic logic [31:0] gold_load(input logic [2:0] f3, input logic [9:0] a);
    return ext(f3, {gold_mem[10'(a + 10'd3)], gold_mem[10'(a + 10'd2)],
                    gold_mem[10'(a + 10'd1)], gold_mem[a]});
  endfunction

  task automatic preload_word(input logic [9:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      env_mem[10'(a + 10'(i))]  = w[8*i +: 8];
      gold_mem[10'(a + 10'(i))] = w[8*i +: 8];
    end
  endtask

  // ---------------- Request driver ----------------
  typedef struct {
    bit          v;
    bit          we;
    logic [2:0]  f3;
    logic [9:0]  addr;
    logic [31:0] wd;
  } op_t;

  op_t op_q0[$];
  op_t op_q1[$];
  op_t cur0, cur1;
  bit  acc0, acc1;

  function automatic op_t mk(input bit we, input logic [2:0] f3, input logic [9:0] a, input logic [31:0] wd);
    op_t o;
    o.v = 1'b1; o.we = we; o.f3 = f3; o.addr = a; o.wd = wd;
    return o;
  endfunction

  always @(negedge clk) begin
    acc0 = req0_ready;
    acc1 = req1_ready;
  end

  initial begin
    cur0 = '{default: 0};
    cur1 = '{default: 0};
    forever begin
      @(posedge clk);
      #1;
      if (!cur0.v || acc0) cur0 = (op_q0.size() > 0) ? op_q0.pop_front() : '{default: 0};
      if (!cur1.v || acc1) cur1 = (op_q1.size() > 0) ? op_q1.pop_front() : '{default: 0};
      req0_valid = cur0.v; req0_we = cur0.we; req0_func3 = cur0.f3;
      req0_addr  = cur0.addr; req0_wdata = cur0.wd;
      req1_valid = cur1.v; req1_we = cur1.we; req1_func3 = cur1.f3;
      req1_addr  = cur1.addr; req1_wdata = cur1.wd;
    end
  end

  // ---------------- Transaction-level reference model ----------------
  typedef struct {
    int          acc;
    int          id;
    bit          we;
    logic [2:0]  f3;
    logic [9:0]  addr;
    logic [31:0] wd;
    bit          mis;
    logic [31:0] data;
  } tx_t;

  tx_t         txq[$];
  int          cyc = 0;
  int          m_last = 1;
  logic [31:0] held0 = 32'd0, held1 = 32'd0;
  bit          started = 1'b0;

  function automatic int winner(input bit v0, input bit v1, input int last);
    if (v0 && v1) return 1 - last;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic bit misaligned(input logic [2:0] f3, input logic [9:0] a);
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    int  w;
    tx_t t;
    if (!reset_n) begin
      txq.delete();
      m_last  = 1;
      held0   = 32'd0;
      held1   = 32'd0;
      started = 1'b1;
    end else begin
      for (int k = 0; k < txq.size(); k++)
        if (txq[k].acc == cyc - 1 && !txq[k].mis) begin
          if (txq[k].we)
            for (int i = 0; i < nbytes(txq[k].f3); i++)
              gold_mem[10'(txq[k].addr + 10'(i))] = txq[k].wd[8*i +: 8];
          else
            txq[k].data = gold_load(txq[k].f3, txq[k].addr);
        end
      if (txq.size() > 0 && txq[0].acc == cyc - 2) begin
        if (txq[0].id == 0) held0 = txq[0].data; else held1 = txq[0].data;
        void'(txq.pop_front());
      end
      w = winner(req0_valid, req1_valid, m_last);
      if (w >= 0) begin
        t.acc = cyc; t.id = w; t.data = 32'd0;
        t.we   = (w == 0) ? req0_we    : req1_we;
        t.f3   = (w == 0) ? req0_func3 : req1_func3;
        t.addr = (w == 0) ? req0_addr  : req1_addr;
        t.wd   = (w == 0) ? req0_wdata : req1_wdata;
        t.mis  = misaligned(t.f3, t.addr);
        txq.push_back(t);
        m_last = w;
      end
    end
    cyc++;
  end

  // ---------------- Per-cycle compare and response logs ----------------
  logic [31:0] rsp_log0[$], rsp_log1[$];
  int          grant_log[$];
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
  logic        err_log0[$];
`endif

  always @(negedge clk) begin
    int   w, ai, ri;
    logic e_rd, e_wr;
    if (started) begin
      w = reset_n ? winner(req0_valid, req1_valid, m_last) : -1;
      chk("ready0", req0_ready, w == 0);
      chk("ready1", req1_ready, w == 1);
      ai = -1; ri = -1;
      for (int k = 0; k < txq.size(); k++) begin
        if (txq[k].acc == cyc - 1) ai = k;
        if (txq[k].acc == cyc - 2) ri = k;
      end
      e_rd = reset_n && ai >= 0 && !txq[ai].we && !txq[ai].mis;
      e_wr = reset_n && ai >= 0 && txq[ai].we && !txq[ai].mis;
      chk("mem_read", mem_read, e_rd);
      chk("mem_write", mem_write, e_wr);
      if (e_rd || e_wr) begin
        chk("mem_addr", mem_addr, txq[ai].addr);
        chk("mem_func3", mem_func3, txq[ai].f3);
        if (e_wr) chk("mem_wdata", mem_wdata, txq[ai].wd);
      end
      chk("rvalid0", req0_rvalid, reset_n && ri >= 0 && txq[ri].id == 0);
      chk("rvalid1", req1_rvalid, reset_n && ri >= 0 && txq[ri].id == 1);
      chk("rdata0", req0_rdata, (ri >= 0 && txq[ri].id == 0) ? txq[ri].data : held0);
      chk("rdata1", req1_rdata, (ri >= 0 && txq[ri].id == 1) ? txq[ri].data : held1);
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
      chk("err0", req0_err, reset_n && ri >= 0 && txq[ri].id == 0 && txq[ri].mis);
      chk("err1", req1_err, reset_n && ri >= 0 && txq[ri].id == 1 && txq[ri].mis);
      if (req0_rvalid) err_log0.push_back(req0_err);
`endif
      if (req0_rvalid) rsp_log0.push_back(req0_rdata);
      if (req1_rvalid) rsp_log1.push_back(req1_rdata);
      if (req0_ready) grant_log.push_back(0);
      if (req1_ready) grant_log.push_back(1);
    end
  end

  // ---------------- Directed tests ----------------
  task automatic drain();
    int n = 0;
    while ((op_q0.size() > 0 || op_q1.size() > 0 || req0_valid || req1_valid) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
    repeat (4) @(posedge clk);
  endtask

  task automatic clear_logs();
    rsp_log0.delete();
    rsp_log1.delete();
    grant_log.delete();
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    err_log0.delete();
`endif
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) begin
      env_mem[i]  = 8'h00;
      gold_mem[i] = 8'h00;
    end

    // Reset held with both requesters pending; req0 must win the first contention
    op_q0.push_back(mk(1'b0, 3'b010, 10'h100, 32'd0));
    op_q1.push_back(mk(1'b0, 3'b010, 10'h104, 32'd0));
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("first_grant_req0", req0_ready, 32'd1);
    chk("first_grant_req1", req1_ready, 32'd0);
    drain();

    // Store then back-to-back load on req0
    clear_logs();
    op_q0.push_back(mk(1'b1, 3'b010, 10'h010, 32'hDEADBEEF));
    op_q0.push_back(mk(1'b0, 3'b010, 10'h010, 32'd0));
    drain();
    chk("sw_lw_count", rsp_log0.size(), 32'd2);
    if (rsp_log0.size() == 2) begin
      chk("sw_rdata_zero", rsp_log0[0], 32'd0);
      chk("lw_after_sw", rsp_log0[1], 32'hDEADBEEF);
    end

    // Byte store and signed/unsigned byte loads on req1
    clear_logs();
    op_q1.push_back(mk(1'b1, 3'b000, 10'h021, 32'h000000AB));
    op_q1.push_back(mk(1'b0, 3'b100, 10'h021, 32'd0));
    op_q1.push_back(mk(1'b0, 3'b000, 10'h021, 32'd0));
    drain();
    chk("byte_count", rsp_log1.size(), 32'd3);
    if (rsp_log1.size() == 3) begin
      chk("lbu_0x021", rsp_log1[1], 32'h000000AB);
      chk("lb_0x021", rsp_log1[2], 32'hFFFFFFAB);
    end

    // Continuous contention alternates starting with req0
    clear_logs();
    preload_word(10'h000, 32'h11223344);
    preload_word(10'h004, 32'h55667788);
    for (int i = 0; i < 4; i++) begin
      op_q0.push_back(mk(1'b0, 3'b010, 10'h000, 32'd0));
      op_q1.push_back(mk(1'b0, 3'b010, 10'h004, 32'd0));
    end
    drain();
    chk("contend_grants", grant_log.size(), 32'd8);
    if (grant_log.size() == 8) begin
      chk("contend_g0", grant_log[0], 32'd0);
      chk("contend_g1", grant_log[1], 32'd1);
      chk("contend_g2", grant_log[2], 32'd0);
      chk("contend_g3", grant_log[3], 32'd1);
    end
    chk("contend_rsp0", rsp_log0.size(), 32'd4);
    chk("contend_rsp1", rsp_log1.size(), 32'd4);
    if (rsp_log0.size() == 4 && rsp_log1.size() == 4) begin
      chk("contend_data0", rsp_log0[3], 32'h11223344);
      chk("contend_data1", rsp_log1[3], 32'h55667788);
    end

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    // Misaligned word load is blocked and flagged; an aligned halfword is not
    clear_logs();
    op_q0.push_back(mk(1'b0, 3'b010, 10'h006, 32'd0));
    op_q0.push_back(mk(1'b0, 3'b001, 10'h006, 32'd0));
    drain();
    chk("mis_count", err_log0.size(), 32'd2);
    if (err_log0.size() == 2 && rsp_log0.size() == 2) begin
      chk("mis_err", err_log0[0], 32'd1);
      chk("mis_rdata", rsp_log0[0], 32'd0);
      chk("lh_err", err_log0[1], 32'd0);
      chk("lh_0x006", rsp_log0[1], 32'h00005566);
    end
`endif

    // Reset during the access cycle of a store suppresses the write and its response
    clear_logs();
    op_q0.push_back(mk(1'b1, 3'b010, 10'h030, 32'h12345678));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req0_ready && n < 20);
    if (n >= 20) chk("midrst_accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    chk("midrst_word", {env_mem[10'h033], env_mem[10'h032], env_mem[10'h031], env_mem[10'h030]}, 32'd0);
    chk("midrst_no_rvalid", rsp_log0.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
